wb_select_stage: RTL
====================

// Module: wb_select_stage
// PURPOSE
//  Registered, parametrised writeback-select stage for the pipelined CPU. It is the successor of the
//  two-input read-data/ALU-result select: it picks one of NUM_SRC result sources and formats load
//  data (byte/half/word, signed/unsigned). It presents the result to the register file through a
//  valid/ready skid buffer, so the pipeline can stall without losing or duplicating a writeback.
// PARAMETERS
//  DATA_W   32  result width; must be >= 32
//  NUM_SRC  4   number of result sources; source 0 is always memory read data; must be >= 2
//  SEL_W    $clog2(NUM_SRC)  derived select width; not overridden
//  RD_W     5   destination register address width
// PORTS
//  clk         in   1                clock, rising edge
//  rst_n       in   1                asynchronous, active-low reset
//  in_valid    in   1                upstream beat valid
//  in_ready    out  1                stage can accept a beat this cycle
//  src_data    in   NUM_SRC*DATA_W   packed sources; source k = bits [k*DATA_W +: DATA_W]
//  src_sel     in   SEL_W            source select
//  load_size   in   2                00 byte, 01 half, 10 word, 11 reserved (source 0 only)
//  load_uns    in   1                1 = zero-extend, 0 = sign-extend (source 0 only)
//  addr_lo     in   2                byte offset of load address (source 0 only)
//  rd_in       in   RD_W             destination register
//  we_in       in   1                register-write request
//  out_valid   out  1                writeback beat valid
//  out_ready   in   1                register file/downstream accepts the beat
//  wb_data     out  DATA_W           formatted result
//  wb_rd       out  RD_W             destination register
//  wb_we       out  1                write enable; forced 0 when wb_rd == 0
//  err_sticky  out  1                sticky format/select error
//  err_clr     in   1                synchronous clear of err_sticky
// BEHAVIOUR
//  - Reset (async assert, sync release): state EMPTY, out_valid=0, wb_data=0, wb_rd=0, wb_we=0,
//    err_sticky=0, skid contents 0. in_ready=1, because it decodes from the EMPTY state.
//  - Accept = in_valid & in_ready. Emit = out_valid & out_ready. Latency from accept to out_valid
//    is 1 cycle; there are no bubbles when out_ready is held at 1 (one beat per cycle).
//  - Two entries: MAIN drives the outputs, SKID holds one overflow beat. States:
//    EMPTY -accept-> ONE;  ONE -accept&!emit-> TWO;  ONE -emit&!accept-> EMPTY;
//    ONE -accept&emit-> ONE (MAIN reloads);  TWO -emit-> ONE (SKID moves to MAIN).
//  - in_ready = (state != TWO), decoded from registered state only. It has no combinational path
//    from out_ready.
//  - out_valid = (state != EMPTY). MAIN is stable while out_valid & !out_ready.
//  - Order is strictly FIFO; no beat is dropped or duplicated.
//  - Select: src_sel < NUM_SRC picks that source. src_sel >= NUM_SRC gives data 0, we forced 0,
//    and sets the error.
//  - Source 0 formatting (addr_lo applies only here):
//    byte: lane = data[8*addr_lo +: 8].
//    half: lane = data[16*addr_lo[1] +: 16].
//    Byte and half lanes are extended to DATA_W: zero-extended if load_uns, else sign-extended.
//    word: data[31:0], extended the same way when DATA_W > 32.
//    Half with addr_lo[0]=1 is misaligned: the result uses addr_lo[1] lane anyway, we forced 0,
//    and the error is set.
//    size 11: treated as word, we forced 0, and the error is set.
//  - Formatting is done before capture, so MAIN/SKID hold final values.
//  - wb_we = stored we & (wb_rd != 0).
//  - err_sticky is set on an accepted erroneous beat, cleared by err_clr. If set and clear occur
//    in the same cycle, set wins.
//  - Inputs are ignored when !in_ready or !in_valid.
//  - Reset mid-operation discards both entries immediately.
// TESTING
//  1 Stream, out_ready=1: 4 beats sel=1, data 0x11,0x22,0x33,0x44 -> out_valid from cycle+1,
//    wb_data in order, one per cycle, in_ready stays 1.
//  2 Backpressure: out_ready=0, send 2 beats -> state TWO, in_ready=0, 3rd beat held upstream.
//    Then out_ready=1 -> 3 beats out in order, none lost.
//  3 Load src0=0x8070F0A5: byte addr_lo=0 signed -> 0xFFFFFFA5; byte addr_lo=1 uns -> 0x000000F0;
//    half addr_lo=2 signed -> 0xFFFF8070; word -> 0x8070F0A5.
//  4 Errors: half addr_lo=1 -> wb_we=0, err_sticky=1. sel=7 with NUM_SRC=4 (SEL_W=2 bench
//    override to 3) -> data 0. err_clr with no new error -> 0. Error beat concurrent with
//    err_clr -> stays 1.
//  5 rd_in=0, we_in=1, sel=2 -> wb_we=0, wb_data still delivered.
//  6 rst_n low while state TWO -> out_valid=0 and in_ready=1 immediately; no stale beat after release.

Source files
------------

// File: rtl/wb_select_if.sv
// Bundle of the writeback-select stage signals: upstream beat, downstream
// valid/ready handshake and the sticky error status/clear.
interface wb_select_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int RD_W    = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]          src_sel;
  logic [1:0]                load_size;
  logic                      load_uns;
  logic [1:0]                addr_lo;
  logic [RD_W-1:0]           rd_in;
  logic                      we_in;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         wb_data;
  logic [RD_W-1:0]           wb_rd;
  logic                      wb_we;
  logic                      err_sticky;
  logic                      err_clr;

  // Side that produces beats and consumes writebacks.
  modport master (
    output in_valid, src_data, src_sel, load_size, load_uns, addr_lo,
           rd_in, we_in, out_ready, err_clr,
    input  in_ready, out_valid, wb_data, wb_rd, wb_we, err_sticky
  );

  // The stage itself.
  modport slave (
    input  in_valid, src_data, src_sel, load_size, load_uns, addr_lo,
           rd_in, we_in, out_ready, err_clr,
    output in_ready, out_valid, wb_data, wb_rd, wb_we, err_sticky
  );
endinterface

// File: rtl/wb_select_stage.sv
// Writeback-select stage: picks one of NUM_SRC result sources, formats load
// data from source 0, and presents the result through a two-entry skid buffer
// (MAIN drives the outputs, SKID holds one overflow beat).
module wb_select_stage #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int RD_W    = 5
) (
  input logic       clk,
  input logic       rst_n,
  wb_select_if.slave bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_reg, state_next;

  logic [DATA_W-1:0] src_arr [NUM_SRC];
  logic [DATA_W-1:0] main_data_reg, skid_data_reg, fmt_data;
  logic [RD_W-1:0]   main_rd_reg, skid_rd_reg;
  logic              main_we_reg, skid_we_reg, fmt_we, fmt_err;
  logic              err_reg;
  logic              accept, emit;
  logic              main_from_in, main_from_skid, skid_from_in;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       word_lane;
  logic              sel_ok;
  logic [DATA_W-1:0] sel_data;

  // Unpack the flat source bus into one word per source.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_arr[gi] = bus.src_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign byte_lane = src_arr[0][8*bus.addr_lo +: 8];
  assign half_lane = src_arr[0][16*bus.addr_lo[1] +: 16];
  assign word_lane = src_arr[0][31:0];

  // Select and format the incoming beat so both entries hold final values.
  always_comb begin
    sel_ok   = 1'b0;
    sel_data = '0;
    fmt_data = '0;
    fmt_err  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.src_sel == SEL_W'(k)) begin
        sel_ok   = 1'b1;
        sel_data = src_arr[k];
      end
    end
    if (!sel_ok) begin
      fmt_err = 1'b1;
    end else if (bus.src_sel == '0) begin
      // The extra top bit is the extension bit; the signed cast replicates it.
      case (bus.load_size)
        2'b00: fmt_data = DATA_W'($signed({~bus.load_uns & byte_lane[7], byte_lane}));
        2'b01: begin
          fmt_data = DATA_W'($signed({~bus.load_uns & half_lane[15], half_lane}));
          fmt_err  = bus.addr_lo[0];
        end
        2'b10: fmt_data = DATA_W'($signed({~bus.load_uns & word_lane[31], word_lane}));
        default: begin
          fmt_data = DATA_W'($signed({~bus.load_uns & word_lane[31], word_lane}));
          fmt_err  = 1'b1;
        end
      endcase
    end else begin
      fmt_data = sel_data;
    end
    fmt_we = bus.we_in & ~fmt_err;
  end

  assign bus.in_ready  = (state_reg != TWO);
  assign bus.out_valid = (state_reg != EMPTY);
  assign accept        = bus.in_valid & bus.in_ready;
  assign emit          = bus.out_valid & bus.out_ready;

  // Next-state and entry-load decode for the two-entry buffer.
  always_comb begin
    state_next     = state_reg;
    main_from_in   = 1'b0;
    main_from_skid = 1'b0;
    skid_from_in   = 1'b0;
    case (state_reg)
      EMPTY: if (accept) begin
        main_from_in = 1'b1;
        state_next   = ONE;
      end
      ONE: begin
        if (accept && emit) begin
          main_from_in = 1'b1;
        end else if (accept) begin
          skid_from_in = 1'b1;
          state_next   = TWO;
        end else if (emit) begin
          state_next = EMPTY;
        end
      end
      TWO: if (emit) begin
        main_from_skid = 1'b1;
        state_next     = ONE;
      end
      default: state_next = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  // MAIN and SKID entry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_reg <= '0;
      main_rd_reg   <= '0;
      main_we_reg   <= 1'b0;
      skid_data_reg <= '0;
      skid_rd_reg   <= '0;
      skid_we_reg   <= 1'b0;
    end else begin
      if (main_from_in) begin
        main_data_reg <= fmt_data;
        main_rd_reg   <= bus.rd_in;
        main_we_reg   <= fmt_we;
      end else if (main_from_skid) begin
        main_data_reg <= skid_data_reg;
        main_rd_reg   <= skid_rd_reg;
        main_we_reg   <= skid_we_reg;
      end
      if (skid_from_in) begin
        skid_data_reg <= fmt_data;
        skid_rd_reg   <= bus.rd_in;
        skid_we_reg   <= fmt_we;
      end
    end
  end

  // Sticky error: an accepted bad beat wins over a concurrent clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 err_reg <= 1'b0;
    else if (accept && fmt_err) err_reg <= 1'b1;
    else if (bus.err_clr)       err_reg <= 1'b0;
  end

  assign bus.wb_data    = main_data_reg;
  assign bus.wb_rd      = main_rd_reg;
  assign bus.wb_we      = main_we_reg & (main_rd_reg != '0);
  assign bus.err_sticky = err_reg;

endmodule
